// File: rtl/fp_wb_scoreboard_if.sv
// Write-back / issue bundle between FP units, decode and the FP scoreboard.
// FPSB_WB_BYPASS_EN adds the forwarding signals.
interface fp_wb_scoreboard_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5
);
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic [REG_AW-1:0]         issue_rs1;
  logic [REG_AW-1:0]         issue_rs2;
  logic                      issue_stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_AW-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_writenable;
  logic [REG_AW-1:0]         rf_writesel;
  logic [DATA_W-1:0]         rf_din;
  logic [2**REG_AW-1:0]      busy_vec;
  logic                      sb_err;
`ifdef FPSB_WB_BYPASS_EN
  logic                      fwd_rs1_hit;
  logic                      fwd_rs2_hit;
  logic [DATA_W-1:0]         fwd_data;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output req_valid, req_rd, req_data,
    input  issue_stall, req_ready,
    input  rf_writenable, rf_writesel, rf_din,
    input  busy_vec, sb_err,
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_data
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  req_valid, req_rd, req_data,
    output issue_stall, req_ready,
    output rf_writenable, rf_writesel, rf_din,
    output busy_vec, sb_err,
    output fwd_rs1_hit, fwd_rs2_hit, fwd_data
  );
`else
  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output req_valid, req_rd, req_data,
    input  issue_stall, req_ready,
    input  rf_writenable, rf_writesel, rf_din,
    input  busy_vec, sb_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  req_valid, req_rd, req_data,
    output issue_stall, req_ready,
    output rf_writenable, rf_writesel, rf_din,
    output busy_vec, sb_err
  );
`endif
endinterface

// File: rtl/fp_wb_scoreboard.sv
// FP write-back round-robin arbiter plus per-register busy scoreboard.
// Optional write-back bypass: define FPSB_WB_BYPASS_EN.
module fp_wb_scoreboard #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_wb_scoreboard_if.slave bus
);
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 2**REG_AW;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic              we_q;
  logic [REG_AW-1:0] sel_q;
  logic [DATA_W-1:0] din_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  logic [REG_AW-1:0] rd_a  [NUM_REQ];
  logic [DATA_W-1:0] dat_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_a[g]  = bus.req_rd[g*REG_AW +: REG_AW];
    assign dat_a[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               xfer;
  logic [REG_AW-1:0]  xfer_rd;
  logic [DATA_W-1:0]  xfer_dat;

  // Search upward from ptr+1 with wrap; first valid wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_idx = ptr_q;
    xfer    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!xfer && bus.req_valid[idx]) begin
        xfer         = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  assign xfer_rd  = rd_a[gnt_idx];
  assign xfer_dat = dat_a[gnt_idx];
  assign ptr_d    = xfer ? gnt_idx : ptr_q;

  logic hit_rs1, hit_rs2, hit_rd;
  logic stall;

`ifdef FPSB_WB_BYPASS_EN
  assign hit_rs1         = xfer && (bus.issue_rs1 == xfer_rd);
  assign hit_rs2         = xfer && (bus.issue_rs2 == xfer_rd);
  assign hit_rd          = xfer && (bus.issue_rd == xfer_rd);
  assign bus.fwd_rs1_hit = hit_rs1;
  assign bus.fwd_rs2_hit = hit_rs2;
  assign bus.fwd_data    = xfer_dat;
`else
  assign hit_rs1 = 1'b0;
  assign hit_rs2 = 1'b0;
  assign hit_rd  = 1'b0;
`endif

  assign stall = bus.issue_valid &&
                 ((busy_q[bus.issue_rs1] && !hit_rs1) ||
                  (busy_q[bus.issue_rs2] && !hit_rs2) ||
                  (busy_q[bus.issue_rd]  && !hit_rd));

  // Clear first so a same-edge issue to the same rd keeps it busy.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (xfer) begin
      if (!busy_q[xfer_rd]) err_d = 1'b1;
      busy_d[xfer_rd] = 1'b0;
    end
    if (bus.issue_valid && !stall) busy_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= PW'(NUM_REQ - 1);
      we_q   <= 1'b0;
      sel_q  <= '0;
      din_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= xfer;
      busy_q <= busy_d;
      err_q  <= err_d;
      if (xfer) begin
        sel_q <= xfer_rd;
        din_q <= xfer_dat;
      end
    end
  end

  assign bus.issue_stall   = stall;
  assign bus.req_ready     = gnt;
  assign bus.rf_writenable = we_q;
  assign bus.rf_writesel   = sel_q;
  assign bus.rf_din        = din_q;
  assign bus.busy_vec      = busy_q;
  assign bus.sb_err        = err_q;
endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Scoreboard bench for fp_wb_scoreboard: directed stimulus, queued
// write-back expectations popped by an independent monitor.
module tb_fp_wb_scoreboard;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_wb_scoreboard_if #(.NUM_REQ(NR), .DATA_W(DW), .REG_AW(AW)) bif();

  fp_wb_scoreboard #(.NUM_REQ(NR), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bif.rf_writenable) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got write sel=%0d din=%h expected none",
                 bif.rf_writesel, bif.rf_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_sel", 32'(bif.rf_writesel), 32'(mon_e.rd));
        chk("wb_din", bif.rf_din, mon_e.d);
      end
    end
  end

  function automatic logic [NR*AW-1:0] pr(input int u, input logic [AW-1:0] rd);
    logic [NR*AW-1:0] r;
    r = '0;
    r[u*AW +: AW] = rd;
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] pd(input int u, input logic [DW-1:0] d);
    logic [NR*DW-1:0] r;
    r = '0;
    r[u*DW +: DW] = d;
    return r;
  endfunction

  task automatic step(input logic iv, input logic [AW-1:0] ird,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [NR-1:0] rv, input logic [NR*AW-1:0] rds,
                      input logic [NR*DW-1:0] dat, input logic es,
                      input logic [NR-1:0] er);
    @(negedge clk);
    bif.issue_valid = iv;
    bif.issue_rd    = ird;
    bif.issue_rs1   = rs1;
    bif.issue_rs2   = rs2;
    bif.req_valid   = rv;
    bif.req_rd      = rds;
    bif.req_data    = dat;
    #1;
    chk("issue_stall", 32'(bif.issue_stall), 32'(es));
    chk("req_ready", 32'(bif.req_ready), 32'(er));
    for (int i = 0; i < NR; i++)
      if (er[i]) exp_q.push_back('{rd: rds[i*AW +: AW], d: dat[i*DW +: DW]});
  endtask

  task automatic iss(input logic [AW-1:0] rd);
    step(1'b1, rd, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic busy_chk(input string nm, input logic [31:0] exp);
    @(posedge clk);
    #1;
    chk(nm, bif.busy_vec, exp);
  endtask

  task automatic zero_inputs();
    bif.issue_valid = 1'b0;
    bif.issue_rd    = '0;
    bif.issue_rs1   = '0;
    bif.issue_rs2   = '0;
    bif.req_valid   = '0;
    bif.req_rd      = '0;
    bif.req_data    = '0;
  endtask

  int               cnt [NR];
  logic [NR*AW-1:0] rr;
  logic [NR*DW-1:0] dd;

  initial begin
    zero_inputs();
    rst_n = 1'b0;
    #3;
    chk("rst_we", 32'(bif.rf_writenable), 32'd0);
    chk("rst_sel", 32'(bif.rf_writesel), 32'd0);
    chk("rst_din", bif.rf_din, 32'd0);
    chk("rst_busy", bif.busy_vec, 32'd0);
    chk("rst_err", 32'(bif.sb_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single write-back from FMUL
    iss(5'd5);
    busy_chk("busy_set5", 32'h0000_0020);
    step(1'b0, '0, '0, '0, 3'b010, pr(1, 5'd5), pd(1, 32'h3F80_0000), 1'b0, 3'b010);
    busy_chk("busy_clr5", 32'd0);
    idle();

    // reset while a write is pending and f3 is busy
    iss(5'd3);
    iss(5'd4);
    step(1'b0, '0, '0, '0, 3'b100, pr(2, 5'd4), pd(2, 32'hDEAD_BEEF), 1'b0, 3'b100);
    @(posedge clk);
    #2;
    chk("pre_rst_we", 32'(bif.rf_writenable), 32'd1);
    chk("pre_rst_busy", bif.busy_vec, 32'h0000_0008);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bif.rf_writenable), 32'd0);
    chk("mid_rst_busy", bif.busy_vec, 32'd0);
    exp_q.delete();
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // round robin: order 0,1,2,0,1,2 after reset
    for (int r = 16; r < 22; r++) iss(AW'(r));
    busy_chk("busy_rr_set", 32'h003F_0000);
    cnt = '{0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++) begin
        rr[i*AW +: AW] = AW'(16 + i + 3 * cnt[i]);
        dd[i*DW +: DW] = 32'hA500_0000 | 32'(16 + i + 3 * cnt[i]);
      end
      step(1'b0, '0, '0, '0, 3'b111, rr, dd, 1'b0, NR'(1 << (c % NR)));
      cnt[c % NR]++;
    end
    idle();
    busy_chk("busy_rr_clr", 32'd0);
    chk("err_after_rr", 32'(bif.sb_err), 32'd0);

    // RAW on f7, cleared by FDIV
    iss(5'd7);
    busy_chk("busy_set7", 32'h0000_0080);
    step(1'b1, 5'd8, 5'd7, '0, '0, '0, '0, 1'b1, '0);
    step(1'b1, 5'd8, 5'd7, '0, '0, '0, '0, 1'b1, '0);
`ifdef FPSB_WB_BYPASS_EN
    step(1'b1, 5'd8, 5'd7, '0, 3'b100, pr(2, 5'd7), pd(2, 32'h4049_0FDB), 1'b0, 3'b100);
    chk("fwd_rs1_hit", 32'(bif.fwd_rs1_hit), 32'd1);
    chk("fwd_rs2_hit_raw", 32'(bif.fwd_rs2_hit), 32'd0);
    chk("fwd_data_raw", bif.fwd_data, 32'h4049_0FDB);
    idle();
`else
    step(1'b1, 5'd8, 5'd7, '0, 3'b100, pr(2, 5'd7), pd(2, 32'h4049_0FDB), 1'b1, 3'b100);
    step(1'b1, 5'd8, 5'd7, '0, '0, '0, '0, 1'b0, '0);
`endif
    busy_chk("busy_raw", 32'h0000_0100);
    step(1'b0, '0, '0, '0, 3'b001, pr(0, 5'd8), pd(0, 32'h0000_0008), 1'b0, 3'b001);
    idle();
    busy_chk("busy_raw_clr", 32'd0);

    // WAW on f9
    iss(5'd9);
`ifdef FPSB_WB_BYPASS_EN
    step(1'b1, 5'd9, 5'd1, 5'd2, 3'b010, pr(1, 5'd9), pd(1, 32'hC000_0000), 1'b0, 3'b010);
    chk("fwd_rs1_miss", 32'(bif.fwd_rs1_hit), 32'd0);
    chk("fwd_rs2_miss", 32'(bif.fwd_rs2_hit), 32'd0);
    chk("fwd_data_waw", bif.fwd_data, 32'hC000_0000);
    busy_chk("busy_waw_setwins", 32'h0000_0200);
`else
    step(1'b1, 5'd9, 5'd1, 5'd2, '0, '0, '0, 1'b1, '0);
    busy_chk("busy_waw_hold", 32'h0000_0200);
`endif
    step(1'b0, '0, '0, '0, 3'b010, pr(1, 5'd9), pd(1, 32'hC040_0000), 1'b0, 3'b010);
    idle();
    busy_chk("busy_waw_clr", 32'd0);

    // write-back to a non-busy register
    chk("err_pre", 32'(bif.sb_err), 32'd0);
    step(1'b0, '0, '0, '0, 3'b100, pr(2, 5'd12), pd(2, 32'h1234_5678), 1'b0, 3'b100);
    @(posedge clk);
    #1;
    chk("err_set", 32'(bif.sb_err), 32'd1);
    chk("err_busy", bif.busy_vec, 32'd0);
    idle();
    idle();
    idle();
    chk("err_sticky", 32'(bif.sb_err), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("err_rst", 32'(bif.sb_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
